// File: rtl/ppm_pkg.sv
// rtl/ppm_pkg.sv - shared state encoding and frame-length helper for the PPM receive path
package ppm_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } ppm_state_e;

  function automatic int ppm_frame_len(input int l, input int n);
    return (2 ** n) * l;
  endfunction

endpackage

// File: rtl/ppm_slot_timer.sv
// rtl/ppm_slot_timer.sv - slot/symbol counters; the first cycle with run high is slot 0 of symbol 0
module ppm_slot_timer
  import ppm_pkg::*;
#(
  parameter int L = 4,
  parameter int N = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     run,
  output logic [$clog2(L+1)-1:0]   slot_ct,
  output logic [N-1:0]             sym_ct,
  output logic                     frame_end
);

  localparam int SW = $clog2(L + 1);

  logic slot_end;

  assign slot_end  = (slot_ct == SW'(L - 1));
  assign frame_end = slot_end && (sym_ct == {N{1'b1}});

  // sym_ct wraps naturally at N bits, so the next frame restarts at symbol 0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_ct <= '0;
      sym_ct  <= '0;
    end else if (!run) begin
      slot_ct <= '0;
      sym_ct  <= '0;
    end else if (slot_end) begin
      slot_ct <= '0;
      sym_ct  <= sym_ct + 1'b1;
    end else begin
      slot_ct <= slot_ct + 1'b1;
    end
  end

endmodule

// File: rtl/ppm_rx_decoder.sv
// rtl/ppm_rx_decoder.sv - PPM frame decoder with valid/ready result register; optional PPM_GLITCH_FILTER_EN
module ppm_rx_decoder
  import ppm_pkg::*;
#(
  parameter int L = 4,
  parameter int N = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         enable,
  input  logic         pulse_in,
  output logic [N-1:0] out_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         out_err,
  output logic         out_overrun,
  output logic         frame_active
);

  localparam int SW = $clog2(L + 1);

  ppm_state_e     state_q, state_d;
  logic           run;
  logic [SW-1:0]  unused_slot_ct;
  logic [N-1:0]   sym_ct;
  logic           frame_end;
  logic           pulse_q, edge_raw;
  logic           ev, done;
  logic [N-1:0]   ev_sym;
  logic           seen, multi;
  logic [N-1:0]   cap;
  logic           seen_eff, multi_eff;
  logic [N-1:0]   cap_eff;

  assign run = enable;

  ppm_slot_timer #(.L(L), .N(N)) u_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .run       (run),
    .slot_ct   (unused_slot_ct),
    .sym_ct    (sym_ct),
    .frame_end (frame_end)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (run)  state_d = RUN;
      RUN:     if (!run) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign frame_active = (state_q == RUN);

  // pulse_q tracks the line even when idle, so a level already high at enable is not an edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pulse_q <= 1'b0;
    else        pulse_q <= pulse_in;
  end

  assign edge_raw = pulse_in & ~pulse_q;

`ifdef PPM_GLITCH_FILTER_EN
  logic         rise_q, fe_q;
  logic [N-1:0] rise_sym_q;

  // A rise is confirmed one cycle later and credited to the symbol it rose in;
  // the frame closes one cycle late so a rise on its last cycle can still count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rise_q     <= 1'b0;
      rise_sym_q <= '0;
      fe_q       <= 1'b0;
    end else begin
      rise_q     <= edge_raw & run;
      rise_sym_q <= sym_ct;
      fe_q       <= frame_end & run;
    end
  end

  assign ev     = rise_q & pulse_in;
  assign ev_sym = rise_sym_q;
  assign done   = fe_q;
`else
  assign ev     = edge_raw & run;
  assign ev_sym = sym_ct;
  assign done   = frame_end & run;
`endif

  assign seen_eff  = seen | ev;
  assign cap_eff   = seen ? cap : ev_sym;
  assign multi_eff = multi | (seen & ev);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seen  <= 1'b0;
      multi <= 1'b0;
      cap   <= '0;
    end else if (done || !run) begin
      seen  <= 1'b0;
      multi <= 1'b0;
      cap   <= '0;
    end else if (ev) begin
      if (!seen) begin
        seen <= 1'b1;
        cap  <= ev_sym;
      end else begin
        multi <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data    <= '0;
      out_valid   <= 1'b0;
      out_err     <= 1'b0;
      out_overrun <= 1'b0;
    end else begin
      out_overrun <= 1'b0;
      if (done) begin
        out_data    <= seen_eff ? cap_eff : '0;
        out_err     <= ~seen_eff | multi_eff;
        out_valid   <= 1'b1;
        out_overrun <= out_valid & ~out_ready;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ppm_rx_decoder.sv
// tb/tb_ppm_rx_decoder.sv - directed checks of frame decode, handshake, abort and reset (L=4, N=2)
module tb_ppm_rx_decoder;
  import ppm_pkg::*;

  localparam int L  = 4;
  localparam int N  = 2;
  localparam int FL = ppm_frame_len(L, N);
`ifdef PPM_GLITCH_FILTER_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif
  localparam int R = FL - 1 + LAT;
  localparam logic [63:0] ALL = '1;
  localparam logic [63:0] NONE = '0;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         enable;
  logic         pulse_in;
  logic [N-1:0] out_data;
  logic         out_valid;
  logic         out_ready;
  logic         out_err;
  logic         out_overrun;
  logic         frame_active;

  int n_checks = 0;
  int n_fail   = 0;
  int obs_v[0:63], obs_d[0:63], obs_e[0:63], obs_o[0:63], obs_a[0:63];

  always #5 clk = ~clk;

  ppm_rx_decoder #(.L(L), .N(N)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .enable       (enable),
    .pulse_in     (pulse_in),
    .out_data     (out_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_err      (out_err),
    .out_overrun  (out_overrun),
    .frame_active (frame_active)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] m(input int lo, input int hi);
    logic [63:0] r;
    r = '0;
    for (int i = lo; i <= hi; i++) r[i] = 1'b1;
    return r;
  endfunction

  task automatic reset_dut();
    @(negedge clk);
    rst_n = 1'b0; enable = 1'b0; pulse_in = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Index c of obs_* holds the outputs seen during cycle c; cycle 0 is the first enable-high cycle
  task automatic run_seq(input logic [63:0] en_v, input logic [63:0] pl_v,
                         input logic [63:0] rd_v, input int ncyc);
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      obs_v[c] = int'(out_valid);
      obs_d[c] = int'(out_data);
      obs_e[c] = int'(out_err);
      obs_o[c] = int'(out_overrun);
      obs_a[c] = int'(frame_active);
      enable    = en_v[c];
      pulse_in  = pl_v[c];
      out_ready = rd_v[c];
    end
    @(negedge clk);
    enable = 1'b0; pulse_in = 1'b0;
  endtask

  initial begin
    int any_v;
    rst_n = 1'b0; enable = 1'b0; pulse_in = 1'b0; out_ready = 1'b0;
    #12;
    check("rst_valid",   int'(out_valid),    0);
    check("rst_data",    int'(out_data),     0);
    check("rst_err",     int'(out_err),      0);
    check("rst_overrun", int'(out_overrun),  0);
    check("rst_active",  int'(frame_active), 0);
    rst_n = 1'b1;

    // single edge in symbol 2
    run_seq(m(0, 15), m(9, 10), ALL, 20);
    check("t1_active_c0", obs_a[0], 0);
    check("t1_active_c1", obs_a[1], 1);
    check("t1_valid_early", obs_v[R-1], 0);
    check("t1_valid", obs_v[R], 1);
    check("t1_data", obs_d[R], 2);
    check("t1_err", obs_e[R], 0);
    check("t1_overrun", obs_o[R], 0);
    check("t1_valid_consumed", obs_v[R+1], 0);

    // no pulse at all
    reset_dut();
    run_seq(m(0, 15), NONE, ALL, 20);
    check("t2_valid", obs_v[R], 1);
    check("t2_data", obs_d[R], 0);
    check("t2_err", obs_e[R], 1);

    // two edges: first symbol reported, error set
    reset_dut();
    run_seq(m(0, 15), m(2, 3) | m(13, 14), ALL, 20);
    check("t3_data", obs_d[R], 0);
    check("t3_err", obs_e[R], 1);

    // back-to-back frames, consumer stalled
    reset_dut();
    run_seq(m(0, 31), m(5, 6) | m(28, 29), NONE, 36);
    check("t4_f0_valid", obs_v[R], 1);
    check("t4_f0_data", obs_d[R], 1);
    check("t4_f0_overrun", obs_o[R], 0);
    check("t4_f1_pre_overrun", obs_o[R+15], 0);
    check("t4_f1_data", obs_d[R+16], 3);
    check("t4_f1_err", obs_e[R+16], 0);
    check("t4_f1_overrun", obs_o[R+16], 1);
    check("t4_overrun_pulse_end", obs_o[R+17], 0);
    check("t4_valid_held", obs_v[R+17], 1);

    // asynchronous reset while a frame runs and a result is held
    @(negedge clk);
    enable = 1'b1;
    repeat (5) @(negedge clk);
    check("t8_pre_active", int'(frame_active), 1);
    check("t8_pre_valid", int'(out_valid), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("t8_valid", int'(out_valid), 0);
    check("t8_data", int'(out_data), 0);
    check("t8_err", int'(out_err), 0);
    check("t8_overrun", int'(out_overrun), 0);
    check("t8_active", int'(frame_active), 0);
    @(negedge clk);
    enable = 1'b0;
    rst_n = 1'b1;

    // rise on the last cycle of frame 0
    reset_dut();
    run_seq(m(0, 31), m(15, 16), ALL, 36);
    check("t5a_f0_data", obs_d[R], 3);
    check("t5a_f0_err", obs_e[R], 0);
    check("t5a_f1_data", obs_d[R+16], 0);
    check("t5a_f1_err", obs_e[R+16], 1);

    // rise on the first cycle of frame 1
    reset_dut();
    run_seq(m(0, 31), m(16, 17), ALL, 36);
    check("t5b_f0_err", obs_e[R], 1);
    check("t5b_f1_valid", obs_v[R+16], 1);
    check("t5b_f1_data", obs_d[R+16], 0);
    check("t5b_f1_err", obs_e[R+16], 0);

    // abort at cycle 7, re-enable at cycle 20
    reset_dut();
    run_seq(m(0, 6) | m(20, 35), m(3, 4) | m(24, 25), ALL, 40);
    check("t6_active_c7", obs_a[7], 1);
    check("t6_active_c8", obs_a[8], 0);
    check("t6_active_c21", obs_a[21], 1);
    any_v = 0;
    for (int c = 0; c < 35 + LAT; c++) any_v = any_v | obs_v[c];
    check("t6_no_early_valid", any_v, 0);
    check("t6_valid", obs_v[35+LAT], 1);
    check("t6_data", obs_d[35+LAT], 1);
    check("t6_err", obs_e[35+LAT], 0);

    // line already high when enable rises
    reset_dut();
    @(negedge clk);
    pulse_in = 1'b1;
    @(negedge clk);
    run_seq(m(0, 15), m(0, 3), ALL, 20);
    check("t7_err", obs_e[R], 1);
    check("t7_data", obs_d[R], 0);

    // single-cycle pulse in symbol 1
    reset_dut();
    run_seq(m(0, 15), m(6, 6), ALL, 20);
    check("t9_valid", obs_v[R], 1);
`ifdef PPM_GLITCH_FILTER_EN
    check("t9_data", obs_d[R], 0);
    check("t9_err", obs_e[R], 1);
`else
    check("t9_data", obs_d[R], 1);
    check("t9_err", obs_e[R], 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ppm_rx_decoder.md
Name: ppm_rx_decoder

Overview:
- Receive-side counterpart of the PPM symbol-slot transmitter.
- Samples a pulse line and times each frame of 2**N symbol positions, each L clocks wide.
- Decodes the position of the rising pulse edge into an N-bit value.
- Presents the value to the link layer on a valid/ready output register with error and overrun flags.

Parameters:
- L, 4, clocks per symbol position (L >= 1).
- N, 2, bits per frame; frame length = (2**N)*L clocks.

Ports:
- clk  input  1  clock.
- rst_n  input  1  reset, asynchronous, active-low.
- enable  input  1  level; high = run frames back-to-back, low = idle/abort.
- pulse_in  input  1  pulse line, already synchronous to clk.
- out_data  output  N  decoded symbol of the last completed frame.
- out_valid  output  1  out_data/out_err hold a result not yet consumed.
- out_ready  input  1  consumer accepts the result when out_valid and out_ready are both high.
- out_err  output  1  last frame had zero or more than one rising edge.
- out_overrun  output  1  one-cycle pulse: an unconsumed result was overwritten.
- frame_active  output  1  high while in RUN.

Behaviour:
- Reset values:
  - out_data=0, out_valid=0, out_err=0, out_overrun=0, frame_active=0.
  - State IDLE; slot_ct=0, sym_ct=0; pulse_q=0; capture flags cleared.
- Edge detect: pulse_q <= pulse_in every cycle, including IDLE; edge = pulse_in & ~pulse_q. A line already high when enable rises is not an edge.
- FSM states:
  - IDLE: counters held at 0. The cycle in which enable is first sampled high is slot 0 of symbol 0 (run = enable, combinational). On that cycle, go to RUN.
  - RUN: slot_ct counts 0..L-1. At L-1 it wraps to 0 and sym_ct increments. Frame end = (slot_ct==L-1) && (sym_ct==2**N-1). At frame end, stay in RUN if enable is still high; next cycle is slot 0 of a new frame.
  - enable low in RUN: go to IDLE next cycle; counters and capture flags clear; partial frame discarded, no result; output register untouched.
- Capture within a frame:
  - First edge: seen<=1, cap<=sym_ct.
  - Any later edge: multi<=1.
  - An edge on the frame-end cycle counts for the ending frame. An edge on the first cycle of the next frame counts for the new frame.
- Result (registered; visible the cycle after frame end):
  - out_data = cap if seen, else 0.
  - out_err = ~seen | multi. On a multi-edge frame, out_data is the first edge's symbol.
  - out_valid <= 1. Flags cleared for the next frame.
- Handshake:
  - out_valid drops the cycle after out_valid && out_ready, unless a new result loads in that same cycle.
  - Load with out_valid=1 and out_ready=0: overwrite and pulse out_overrun for 1 cycle.
  - Load with out_ready=1: no overrun.
- Latency: frame end cycle + 1 to out_valid.
- Widths: slot_ct is $clog2(L+1) bits; sym_ct is N bits, and its compare to 2**N-1 is done at width N.

Optional Feature:
- PPM_GLITCH_FILTER_EN defined:
  - An edge is accepted only if pulse_in stays high on the following cycle as well.
  - The accepted edge is attributed to the symbol in effect on the rising cycle; that symbol is registered one cycle.
  - On the frame-end cycle, a rise confirmed on the first cycle of the next frame is credited to the ending frame.
  - Result latency becomes frame end + 2 cycles.
  - Single-cycle glitches are ignored entirely.
- Not defined: raw edge accepted as described above; latency frame end + 1.

Decomposition:
- ppm_pkg:
  - state enum {IDLE, RUN}.
  - Function ppm_frame_len(L,N) returning (2**N)*L.
- Sub-module ppm_slot_timer:
  - Inputs: run, clk, rst_n.
  - Outputs: slot_ct, sym_ct, frame_end.
  - Same slot/symbol counting as the transmitter, so both ends share cycle alignment.
- Decoder core: FSM, edge detect, capture, output register.

Test Plan (L=4, N=2, frame 16 cycles, cycle 0 = first enable-high cycle; default build):
- Single edge at cycle 9 (sym 2, slot 1), pulse low elsewhere, out_ready=1 -> cycle 16: out_valid=1, out_data=2, out_err=0, out_overrun=0.
- No pulse in frame -> cycle 16: out_valid=1, out_data=0, out_err=1.
- Edges at cycles 2 and 13 -> out_data=0, out_err=1.
- Back-to-back frames with out_ready=0, edges at cycles 5 and 28:
  - Cycle 16: out_data=1.
  - Cycle 32: out_data=3 and out_overrun=1 for one cycle.
- Edges on cycle 15 and cycle 16:
  - Frame 0 result: out_data=3, err=0.
  - Frame 1 result: out_data=0, err=0.
- enable dropped at cycle 7 after an edge at cycle 3 -> no out_valid; frame_active=0 from cycle 8.
- Re-enable at cycle 20 with an edge at cycle 24 -> result out_data=1 at cycle 36.
- Reset asserted mid-frame -> all outputs 0 immediately.
- Glitch-filter build: 1-cycle pulse at cycle 6 ignored -> out_err=1, result visible at cycle 17.
